// File: rtl/ucie_sb_pkg.sv
// +------------------------------------------------------------------+
// | ucie_sb_pkg : shared types and constants for the sideband TX path |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package ucie_sb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } sb_state_t;

  localparam int SB_PKT_W  = 64;
  localparam int SB_GAP_UI = 32;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ucie_sb_sync_fifo.sv
// +------------------------------------------------------------------+
// | ucie_sb_sync_fifo : packet FIFO with registered full/empty/count  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module ucie_sb_sync_fifo
  import ucie_sb_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A push while full is refused even if a pop frees a slot this cycle.
  assign w_push_ok = push & ~r_full;
  assign w_pop_ok  = pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ucie_sb_tx_serializer.sv
// +------------------------------------------------------------------+
// | ucie_sb_tx_serializer : buffered sideband TX packet serializer    |
// | Optional packet counter port enabled by UCIE_SB_TX_CNT_EN. Rev 1.0|
// +------------------------------------------------------------------+
`default_nettype none

module ucie_sb_tx_serializer
  import ucie_sb_pkg::*;
#(
  parameter int PKT_W  = SB_PKT_W,
  parameter int LANES  = 1,
  parameter int DEPTH  = 4,
  parameter int GAP_UI = SB_GAP_UI
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PKT_W-1:0]         in_data,
  input  logic                     tx_en,
  output logic                     SBTX_CLK,
  output logic [LANES-1:0]         SBTX_DATA,
  output logic                     busy,
  output logic [cnt_w(DEPTH)-1:0]  fifo_count
`ifdef UCIE_SB_TX_CNT_EN
  ,
  output logic [31:0]              pkt_sent_cnt
`endif
);

  localparam int UIS     = PKT_W / LANES;
  localparam int UI_W    = cnt_w(UIS);
  localparam int GAP_CYC = 2 * GAP_UI;
  localparam int GAP_W   = cnt_w(GAP_CYC);

  sb_state_t        r_state;
  logic             r_phase_h;
  logic [UI_W-1:0]  r_ui_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [PKT_W-1:0] r_shift;
  logic [PKT_W-1:0] w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_pop;
  logic             w_gap_last;
  logic             w_ui_last;
  logic             w_pkt_done;

  assign w_gap_last = (r_gap_cnt == GAP_W'(GAP_CYC - 1));
  assign w_ui_last  = (r_ui_cnt == UI_W'(UIS - 1));
  assign w_pkt_done = (r_state == ST_SHIFT) && r_phase_h && w_ui_last;
  assign in_ready   = ~w_fifo_full;

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = ~w_fifo_empty & tx_en;
      ST_GAP:  w_pop = w_gap_last & ~w_fifo_empty & tx_en;
      default: w_pop = 1'b0;
    endcase
  end

  ucie_sb_sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_phase_h <= 1'b0;
      r_ui_cnt  <= '0;
      r_gap_cnt <= '0;
      r_shift   <= '0;
      SBTX_CLK  <= 1'b0;
      SBTX_DATA <= '0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          SBTX_CLK  <= 1'b0;
          SBTX_DATA <= '0;
          if (w_pop) begin
            r_shift   <= w_head;
            r_ui_cnt  <= '0;
            r_phase_h <= 1'b0;
            r_state   <= ST_SHIFT;
            busy      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // L phase presents the next lane group; H phase raises the clock on stable data.
          if (!r_phase_h) begin
            SBTX_CLK  <= 1'b0;
            SBTX_DATA <= r_shift[LANES-1:0];
            r_shift   <= r_shift >> LANES;
            r_phase_h <= 1'b1;
          end else begin
            SBTX_CLK  <= 1'b1;
            r_phase_h <= 1'b0;
            r_ui_cnt  <= r_ui_cnt + 1'b1;
            if (w_ui_last) begin
              r_state   <= ST_GAP;
              r_gap_cnt <= '0;
            end
          end
        end
        ST_GAP: begin
          SBTX_CLK  <= 1'b0;
          SBTX_DATA <= '0;
          r_gap_cnt <= r_gap_cnt + 1'b1;
          if (w_gap_last) begin
            if (w_pop) begin
              r_shift   <= w_head;
              r_ui_cnt  <= '0;
              r_phase_h <= 1'b0;
              r_state   <= ST_SHIFT;
            end else begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef UCIE_SB_TX_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_sent_cnt <= '0;
    end else if (w_pkt_done) begin
      pkt_sent_cnt <= pkt_sent_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ucie_sb_tx_serializer.sv
// +------------------------------------------------------------------+
// | tb_ucie_sb_tx_serializer : directed bench for the sideband TX     |
// | serializer (LANES=1 and LANES=2 instances). Rev 1.0               |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ucie_sb_tx_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, tx_en, SBTX_CLK, busy;
  logic [63:0] in_data;
  logic [0:0]  SBTX_DATA;
  logic [2:0]  fifo_count;

  logic        in_valid2, in_ready2, tx_en2, sbtx_clk2, busy2;
  logic [63:0] in_data2;
  logic [1:0]  sbtx_data2;
  logic [2:0]  fifo_count2;

`ifdef UCIE_SB_TX_CNT_EN
  logic [31:0] pkt_sent_cnt, pkt_sent_cnt2;
`endif

  int tests = 0;
  int fails = 0;

  int          rises, first_rise, noisy, rises2;
  logic [63:0] cap;
  logic [31:0] cap2a, cap2b;

  logic [63:0] pk [4] = '{64'hDEAD_BEEF_0123_4567, 64'h8000_0000_0000_0001,
                          64'h0F0F_F0F0_3C3C_C3C3, 64'hFFFF_FFFF_FFFF_FFFE};

  always #5 clk = ~clk;

  ucie_sb_tx_serializer #(.PKT_W(64), .LANES(1), .DEPTH(4), .GAP_UI(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tx_en(tx_en), .SBTX_CLK(SBTX_CLK), .SBTX_DATA(SBTX_DATA), .busy(busy),
    .fifo_count(fifo_count)
`ifdef UCIE_SB_TX_CNT_EN
    , .pkt_sent_cnt(pkt_sent_cnt)
`endif
  );

  ucie_sb_tx_serializer #(.PKT_W(64), .LANES(2), .DEPTH(4), .GAP_UI(32)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .tx_en(tx_en2), .SBTX_CLK(sbtx_clk2), .SBTX_DATA(sbtx_data2), .busy(busy2),
    .fifo_count(fifo_count2)
`ifdef UCIE_SB_TX_CNT_EN
    , .pkt_sent_cnt(pkt_sent_cnt2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rises = 0; first_rise = -1; noisy = 0; rises2 = 0;
    cap = '0; cap2a = '0; cap2b = '0;
  endtask

  // Advance n cycles, recording the data present at each forwarded-clock rise.
  task automatic watch(input int n);
    logic p1, p2;
    for (int i = 0; i < n; i++) begin
      p1 = SBTX_CLK;
      p2 = sbtx_clk2;
      tick();
      if (!p1 && SBTX_CLK) begin
        if (rises < 64) cap[rises] = SBTX_DATA[0];
        if (first_rise < 0) first_rise = i;
        rises++;
      end
      if (SBTX_CLK || SBTX_DATA != 0) noisy++;
      if (!p2 && sbtx_clk2) begin
        if (rises2 < 32) begin
          cap2a[rises2] = sbtx_data2[0];
          cap2b[rises2] = sbtx_data2[1];
        end
        rises2++;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (SBTX_CLK !== 1'b0) begin fails++; $display("FAIL reset_clk: got %b want 0", SBTX_CLK); end
    tests++; if (SBTX_DATA !== 1'b0) begin fails++; $display("FAIL reset_data: got %b want 0", SBTX_DATA); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    tests++; if (sbtx_clk2 !== 1'b0 || sbtx_data2 !== 2'b00) begin fails++; $display("FAIL reset_lane2: got %b/%b want 0/00", sbtx_clk2, sbtx_data2); end
  endtask

  task automatic test_single();
    tx_en = 1'b1;
    in_valid = 1'b1; in_data = 64'hA5A5_0000_FFFF_1234;
    tick();
    in_valid = 1'b0;
    tests++; if (fifo_count !== 3'd1 || busy !== 1'b0) begin fails++; $display("FAIL single_accept: got cnt=%0d busy=%b want 1/0", fifo_count, busy); end
    tick();
    tests++; if (fifo_count !== 3'd0 || busy !== 1'b1) begin fails++; $display("FAIL single_pop: got cnt=%0d busy=%b want 0/1", fifo_count, busy); end
    clear_mon();
    watch(128);
    tests++; if (rises !== 64) begin fails++; $display("FAIL single_rises: got %0d want 64", rises); end
    tests++; if (first_rise !== 1) begin fails++; $display("FAIL single_first_rise: got %0d want 1", first_rise); end
    tests++; if (cap !== 64'hA5A5_0000_FFFF_1234) begin fails++; $display("FAIL single_data: got %h want a5a50000ffff1234", cap); end
    clear_mon();
    watch(63);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_gap_busy: got %b want 1", busy); end
    watch(1);
    tests++; if (noisy !== 0) begin fails++; $display("FAIL single_gap_quiet: got %0d active cycles want 0", noisy); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_cnt [4] = '{3'd2, 3'd1, 3'd0, 3'd0};
    tx_en = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = pk[k];
      tick();
      if (k < 3) begin
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_%0d: got %b want 1", k, in_ready); end
      end
    end
    tests++; if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin fails++; $display("FAIL b2b_full: got ready=%b cnt=%0d want 0/4", in_ready, fifo_count); end
    // Offer a fifth packet on the same edge the first pop happens: it must be refused.
    in_data = 64'h5555_5555_5555_5555;
    tx_en = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++; if (fifo_count !== 3'd3 || in_ready !== 1'b1) begin fails++; $display("FAIL b2b_full_pop: got cnt=%0d ready=%b want 3/1", fifo_count, in_ready); end
    for (int k = 0; k < 4; k++) begin
      clear_mon();
      watch(192);
      tests++; if (rises !== 64 || first_rise !== 1) begin fails++; $display("FAIL b2b_timing_%0d: got rises=%0d first=%0d want 64/1", k, rises, first_rise); end
      tests++; if (cap !== pk[k]) begin fails++; $display("FAIL b2b_data_%0d: got %h want %h", k, cap, pk[k]); end
      tests++; if (fifo_count !== exp_cnt[k]) begin fails++; $display("FAIL b2b_count_%0d: got %0d want %0d", k, fifo_count, exp_cnt[k]); end
      tests++; if (busy !== (k < 3)) begin fails++; $display("FAIL b2b_busy_%0d: got %b want %b", k, busy, k < 3); end
    end
    clear_mon();
    watch(30);
    tests++; if (rises !== 0) begin fails++; $display("FAIL b2b_refused_sent: got %0d rises want 0", rises); end
  endtask

  task automatic test_lanes2();
    tx_en2 = 1'b1;
    in_valid2 = 1'b1; in_data2 = 64'h1;
    tick();
    in_data2 = 64'hFFFF_0000_0000_0002;
    tick();
    in_valid2 = 1'b0;
    clear_mon();
    watch(64);
    tests++; if (rises2 !== 32) begin fails++; $display("FAIL lane2_rises_a: got %0d want 32", rises2); end
    tests++; if (cap2a !== 32'h1 || cap2b !== 32'h0) begin fails++; $display("FAIL lane2_data_a: got l0=%h l1=%h want 00000001/00000000", cap2a, cap2b); end
    clear_mon();
    watch(64);
    tests++; if (rises2 !== 0) begin fails++; $display("FAIL lane2_gap: got %0d rises want 0", rises2); end
    clear_mon();
    watch(64);
    tests++; if (rises2 !== 32) begin fails++; $display("FAIL lane2_rises_b: got %0d want 32", rises2); end
    tests++; if (cap2a !== 32'hFF00_0000 || cap2b !== 32'hFF00_0001) begin fails++; $display("FAIL lane2_data_b: got l0=%h l1=%h want ff000000/ff000001", cap2a, cap2b); end
    watch(64);
    tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL lane2_idle: got busy=%b want 0", busy2); end
  endtask

  task automatic test_tx_en();
    do_reset();
    tx_en = 1'b0;
    in_valid = 1'b1; in_data = pk[2];
    tick();
    in_data = pk[1];
    tick();
    in_valid = 1'b0;
    clear_mon();
    watch(10);
    tests++; if (rises !== 0 || noisy !== 0 || busy !== 1'b0) begin fails++; $display("FAIL txen_hold: got rises=%0d noisy=%0d busy=%b want 0/0/0", rises, noisy, busy); end
    tests++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL txen_hold_count: got %0d want 2", fifo_count); end
    tx_en = 1'b1;
    tick();
    tests++; if (busy !== 1'b1 || fifo_count !== 3'd1) begin fails++; $display("FAIL txen_pop: got busy=%b cnt=%0d want 1/1", busy, fifo_count); end
    clear_mon();
    watch(40);
    tx_en = 1'b0;
    watch(88);
    tests++; if (rises !== 64 || cap !== pk[2]) begin fails++; $display("FAIL txen_complete: got rises=%0d data=%h want 64/%h", rises, cap, pk[2]); end
    clear_mon();
    watch(63);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL txen_gap_kept: got busy=%b want 1", busy); end
    watch(1);
    tests++; if (busy !== 1'b0 || fifo_count !== 3'd1 || noisy !== 0) begin fails++; $display("FAIL txen_to_idle: got busy=%b cnt=%0d noisy=%0d want 0/1/0", busy, fifo_count, noisy); end
    clear_mon();
    watch(40);
    tests++; if (rises !== 0 || fifo_count !== 3'd1) begin fails++; $display("FAIL txen_second_held: got rises=%0d cnt=%0d want 0/1", rises, fifo_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tx_en = 1'b1;
    in_valid = 1'b1; in_data = pk[0];
    tick();
    in_data = pk[3];
    tick();
    in_valid = 1'b0;
    tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL rmid_queued: got %0d want 1", fifo_count); end
    clear_mon();
    watch(41);
    tests++; if (rises !== 20) begin fails++; $display("FAIL rmid_rises: got %0d want 20", rises); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (SBTX_CLK !== 1'b0 || SBTX_DATA !== 1'b0) begin fails++; $display("FAIL rmid_pins: got clk=%b data=%b want 0/0", SBTX_CLK, SBTX_DATA); end
    tests++; if (fifo_count !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rmid_state: got cnt=%0d ready=%b busy=%b want 0/1/0", fifo_count, in_ready, busy); end
    clear_mon();
    watch(200);
    tests++; if (rises !== 0 || noisy !== 0) begin fails++; $display("FAIL rmid_silent: got rises=%0d noisy=%0d want 0/0", rises, noisy); end
  endtask

`ifdef UCIE_SB_TX_CNT_EN
  task automatic test_pkt_cnt();
    do_reset();
    tests++; if (pkt_sent_cnt !== 32'd0) begin fails++; $display("FAIL cnt_reset: got %0d want 0", pkt_sent_cnt); end
    tx_en = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = pk[k];
      tick();
    end
    in_valid = 1'b0;
    watch(3 * 192 + 10);
    tests++; if (pkt_sent_cnt !== 32'd3) begin fails++; $display("FAIL cnt_three: got %0d want 3", pkt_sent_cnt); end
    force dut.pkt_sent_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.pkt_sent_cnt;
    in_valid = 1'b1; in_data = pk[3];
    tick();
    in_valid = 1'b0;
    watch(200);
    tests++; if (pkt_sent_cnt !== 32'd0) begin fails++; $display("FAIL cnt_wrap: got %h want 0", pkt_sent_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; tx_en = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; tx_en2 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_lanes2();
    test_tx_en();
    test_reset_mid();
`ifdef UCIE_SB_TX_CNT_EN
    test_pkt_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
